// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with frame-synchronous loading, per-digit dp/blink, and blanking.
// Optional feature: define LZB_EN for leading-zero blanking of the active data.
module seg_scan_driver #(
  parameter int unsigned NUM_DIG   = 6,
  parameter int unsigned SCAN_CYC  = 1000,
  parameter int unsigned BLANK_CYC = 50,
  parameter int unsigned BLINK_CYC = 12_500_000
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic [4*NUM_DIG-1:0] din,
  input  logic [NUM_DIG-1:0]   dp_in,
  input  logic [NUM_DIG-1:0]   blink_in,
  input  logic                 en,
  output logic [7:0]           seg,
  output logic [NUM_DIG-1:0]   sel,
  output logic                 frame_sync
);

  localparam int unsigned SCAN_W  = (SCAN_CYC  > 1) ? $clog2(SCAN_CYC)  : 1;
  localparam int unsigned IDX_W   = (NUM_DIG   > 1) ? $clog2(NUM_DIG)   : 1;
  localparam int unsigned BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam int unsigned DIN_W   = 4 * NUM_DIG;

  logic [SCAN_W-1:0]  cnt_scan_q, cnt_scan_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLINK_W-1:0] cnt_blink_q, cnt_blink_d;
  logic               blink_on_q, blink_on_d;
  logic               pending_q, pending_d;
  logic [DIN_W-1:0]   sh_din_q, sh_din_d;
  logic [NUM_DIG-1:0] sh_dp_q, sh_dp_d;
  logic [NUM_DIG-1:0] sh_blink_q, sh_blink_d;
  logic [DIN_W-1:0]   act_din_q, act_din_d;
  logic [NUM_DIG-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIG-1:0] act_blink_q, act_blink_d;
  logic [7:0]         seg_q, seg_d;
  logic [NUM_DIG-1:0] sel_q, sel_d;
  logic               fs_q, fs_d;

  logic               scan_wrap;
  logic               frame_edge;
  logic               blink_wrap;
  logic               in_blank;
  logic               lz_blank;
  logic [3:0]         cur_nib;
  logic               cur_dp;
  logic               cur_blink;

  // Active-low segment pattern {g,f,e,d,c,b,a} for a hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign scan_wrap  = (cnt_scan_q == SCAN_W'(SCAN_CYC - 1));
  assign frame_edge = scan_wrap && (idx_q == IDX_W'(NUM_DIG - 1));
  assign blink_wrap = (cnt_blink_q == BLINK_W'(BLINK_CYC - 1));

  generate
    if (BLANK_CYC > 0) begin : g_blank
      assign in_blank = (cnt_scan_q < SCAN_W'(BLANK_CYC));
    end else begin : g_no_blank
      assign in_blank = 1'b0;
    end
  endgenerate

  // Current digit's nibble, dp and blink bit from the active registers
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    for (int i = 0; i < int'(NUM_DIG); i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = act_din_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_blink = act_blink_q[i];
      end
    end
  end

`ifdef LZB_EN
  logic [IDX_W-1:0] lz_hi;

  // Highest non-zero digit; anything above it is a leading zero
  always_comb begin
    lz_hi = '0;
    for (int i = 0; i < int'(NUM_DIG); i++) begin
      if (act_din_q[4*i +: 4] != 4'h0) lz_hi = IDX_W'(i);
    end
  end

  assign lz_blank = (idx_q > lz_hi);
`else
  assign lz_blank = 1'b0;
`endif

  // Next-state for counters, shadow/active data and registered outputs
  always_comb begin
    cnt_scan_d  = scan_wrap ? '0 : cnt_scan_q + SCAN_W'(1);
    idx_d       = idx_q;
    cnt_blink_d = blink_wrap ? '0 : cnt_blink_q + BLINK_W'(1);
    blink_on_d  = blink_wrap ? ~blink_on_q : blink_on_q;
    pending_d   = pending_q;
    sh_din_d    = sh_din_q;
    sh_dp_d     = sh_dp_q;
    sh_blink_d  = sh_blink_q;
    act_din_d   = act_din_q;
    act_dp_d    = act_dp_q;
    act_blink_d = act_blink_q;
    seg_d       = 8'hFF;
    sel_d       = '1;
    fs_d        = 1'b0;

    if (scan_wrap) begin
      idx_d = (idx_q == IDX_W'(NUM_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    // Boundary takes the old shadow; a same-cycle load stays pending
    if (frame_edge && pending_q) begin
      act_din_d   = sh_din_q;
      act_dp_d    = sh_dp_q;
      act_blink_d = sh_blink_q;
      pending_d   = 1'b0;
      fs_d        = 1'b1;
    end
    if (load) begin
      sh_din_d   = din;
      sh_dp_d    = dp_in;
      sh_blink_d = blink_in;
      pending_d  = 1'b1;
    end

    if (en) begin
      if (!(cur_blink && !blink_on_q)) begin
        if (lz_blank) seg_d = cur_dp ? 8'h7F : 8'hFF;
        else          seg_d = {~cur_dp, hex7(cur_nib)};
      end
      if (!in_blank) sel_d = ~(NUM_DIG'(1) << idx_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_scan_q  <= '0;
      idx_q       <= '0;
      cnt_blink_q <= '0;
      blink_on_q  <= 1'b1;
      pending_q   <= 1'b0;
      sh_din_q    <= '0;
      sh_dp_q     <= '0;
      sh_blink_q  <= '0;
      act_din_q   <= '0;
      act_dp_q    <= '0;
      act_blink_q <= '0;
      seg_q       <= 8'hFF;
      sel_q       <= '1;
      fs_q        <= 1'b0;
    end else begin
      cnt_scan_q  <= cnt_scan_d;
      idx_q       <= idx_d;
      cnt_blink_q <= cnt_blink_d;
      blink_on_q  <= blink_on_d;
      pending_q   <= pending_d;
      sh_din_q    <= sh_din_d;
      sh_dp_q     <= sh_dp_d;
      sh_blink_q  <= sh_blink_d;
      act_din_q   <= act_din_d;
      act_dp_q    <= act_dp_d;
      act_blink_q <= act_blink_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
      fs_q        <= fs_d;
    end
  end

  assign seg        = seg_q;
  assign sel        = sel_q;
  assign frame_sync = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed and random steps checked cycle by cycle against a time-based model.
// Honours LZB_EN when the design is built with it.
module tb_seg_scan_driver;

  localparam int unsigned ND    = 6;
  localparam int unsigned SCAN  = 10;
  localparam int unsigned BLANK = 2;
  localparam int unsigned BLINK = 100;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          load = 1'b0;
  logic [23:0]   din = '0;
  logic [5:0]    dp_in = '0;
  logic [5:0]    blink_in = '0;
  logic          en = 1'b1;
  logic [7:0]    seg;
  logic [5:0]    sel;
  logic          frame_sync;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Model: cycles since reset release plus shadow/active copies of the loaded data
  int unsigned n_cyc;
  logic [23:0] m_sh_din, m_act_din;
  logic [5:0]  m_sh_dp, m_act_dp, m_sh_bl, m_act_bl;
  logic        m_pend;
  logic [7:0]  exp_seg;
  logic [5:0]  exp_sel;
  logic        exp_fs;

  logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan_driver #(.NUM_DIG(ND), .SCAN_CYC(SCAN), .BLANK_CYC(BLANK), .BLINK_CYC(BLINK)) dut (
    .clk(clk), .rstn(rstn), .load(load), .din(din), .dp_in(dp_in), .blink_in(blink_in),
    .en(en), .seg(seg), .sel(sel), .frame_sync(frame_sync)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    n_cyc = 0;
    m_sh_din = '0; m_act_din = '0;
    m_sh_dp = '0;  m_act_dp = '0;
    m_sh_bl = '0;  m_act_bl = '0;
    m_pend = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    vectors++;
    assert (seg === exp_seg) else begin
      miscompares++;
      $error("FAIL %s seg cyc=%0d observed=%h expected=%h", tag, n_cyc, seg, exp_seg);
    end
    vectors++;
    assert (sel === exp_sel) else begin
      miscompares++;
      $error("FAIL %s sel cyc=%0d observed=%b expected=%b", tag, n_cyc, sel, exp_sel);
    end
    vectors++;
    assert (frame_sync === exp_fs) else begin
      miscompares++;
      $error("FAIL %s frame_sync cyc=%0d observed=%b expected=%b", tag, n_cyc, frame_sync, exp_fs);
    end
  endtask

  // One clock: predict outputs from the current time/state, advance the model, compare after the edge
  task automatic tick(input string tag);
    int unsigned pos, dig, hi;
    logic        ph_on, bnd, lz;
    logic [3:0]  nib;
    pos   = n_cyc % SCAN;
    dig   = (n_cyc / SCAN) % ND;
    ph_on = ((n_cyc / BLINK) % 2) == 0;
    bnd   = (pos == SCAN - 1) && (dig == ND - 1);
    nib   = 4'(m_act_din >> (4 * dig));
    hi = 0;
    for (int i = 0; i < int'(ND); i++)
      if (4'(m_act_din >> (4 * i)) != 4'h0) hi = i;
    lz = 1'b0;
`ifdef LZB_EN
    lz = (dig > hi);
`endif
    if (!en || (m_act_bl[dig] && !ph_on)) exp_seg = 8'hFF;
    else if (lz) exp_seg = m_act_dp[dig] ? 8'h7F : 8'hFF;
    else exp_seg = {~m_act_dp[dig], lut[nib][6:0]};
    exp_sel = (!en || pos < BLANK) ? 6'h3F : ~(6'(1) << dig);
    exp_fs  = bnd && m_pend;
    if (bnd && m_pend) begin
      m_act_din = m_sh_din; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl;
      m_pend = 1'b0;
    end
    if (load) begin
      m_sh_din = din; m_sh_dp = dp_in; m_sh_bl = blink_in;
      m_pend = 1'b1;
    end
    n_cyc++;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic run(input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) tick(tag);
  endtask

  task automatic do_load(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl, input string tag);
    din = d; dp_in = dp; blink_in = bl; load = 1'b1;
    tick(tag);
    load = 1'b0;
    din = 24'($urandom); dp_in = 6'($urandom); blink_in = 6'($urandom);
  endtask

  initial begin
    model_reset();
    #23;
    exp_seg = 8'hFF; exp_sel = 6'h3F; exp_fs = 1'b0;
    check_outputs("reset");
    @(posedge clk); #3;
    rstn = 1'b1;
    @(posedge clk); #1;
    // The edge just taken was the first counted cycle
    exp_seg = 8'hC0; exp_sel = 6'h3F; exp_fs = 1'b0;
    n_cyc = 1;
    check_outputs("first_cycle");

    run(69, "idle_scan");
    do_load(24'h123456, 6'b000100, 6'b000000, "load_mid");
    run(130, "load_apply");
    do_load(24'h111111, 6'b000000, 6'b000000, "load_a");
    run(4, "between_loads");
    do_load(24'h222222, 6'b000000, 6'b000000, "load_b");
    run(130, "latest_wins");
    do_load(24'h000008, 6'b000000, 6'b000001, "load_blink");
    run(300, "blink");
    do_load(24'h000405, 6'b100000, 6'b000000, "load_lzb");
    run(120, "lzb_pattern");
    en = 1'b0;
    run(500, "en_off");
    en = 1'b1;
    run(100, "en_on");

    // Boundary-cycle load: land the strobe exactly on the frame edge
    while ((n_cyc % (SCAN * ND)) != SCAN * ND - 1) tick("align");
    do_load(24'hABCDEF, 6'b010101, 6'b000000, "load_on_edge");
    run(130, "edge_followup");

    for (int k = 0; k < 3000; k++) begin
      en = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 19) == 0) do_load(24'($urandom), 6'($urandom), 6'($urandom), "rand_load");
      else tick("rand");
    end

    // Mid-frame reset with a load pending
    en = 1'b1;
    do_load(24'h987654, 6'b000011, 6'b000000, "pre_reset_load");
    run(7, "pre_reset");
    rstn = 1'b0;
    #1;
    exp_seg = 8'hFF; exp_sel = 6'h3F; exp_fs = 1'b0;
    check_outputs("async_reset");
    model_reset();
    #1;
    rstn = 1'b1;
    run(200, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
